// File: rtl/rx_bit_engine.sv
// Serial receive bit engine: start-bit detection, mid-bit sampling and frame shift-in.
// Delivers the raw left-justified shift register plus ready/framing/overrun flags.
module rx_bit_engine (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic [18:0] i_k,
  input  logic        i_eight,
  input  logic        i_pen,
  input  logic        i_read,
  output logic [9:0]  o_data,
  output logic        o_rxrdy,
  output logic        o_ferr,
  output logic        o_ovf
);

  localparam int unsigned KW = 19;
  localparam int unsigned DW = 10;
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic [KW-1:0]   cnt;
  logic [KW-1:0]   k_lat;
  logic [BW-1:0]   n_lat;
  logic [BW-1:0]   bitcnt;
  logic [DW-1:0]   shreg;
  logic            done;
  logic            expire_c;

  assign expire_c = (cnt == KW'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      k_lat   <= '0;
      n_lat   <= '0;
      bitcnt  <= '0;
      shreg   <= '1;
      done    <= 1'b0;
      o_data  <= '1;
      o_rxrdy <= 1'b0;
      o_ferr  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
      done  <= 1'b0;

      // Frame sequencer; frame format is frozen at start-bit detection.
      case (state)
        IDLE: begin
          if (!sync2) begin
            state  <= START;
            cnt    <= i_k >> 1;
            k_lat  <= i_k;
            n_lat  <= BW'(8) + BW'(i_eight) + BW'(i_pen);
            bitcnt <= '0;
            shreg  <= '1;
          end
        end
        START: begin
          if (expire_c) begin
            if (sync2) begin
              state <= IDLE;
            end else begin
              state <= SHIFT;
              cnt   <= k_lat;
            end
          end else begin
            cnt <= cnt - KW'(1);
          end
        end
        SHIFT: begin
          if (expire_c) begin
            shreg  <= {sync2, shreg[DW-1:1]};
            bitcnt <= bitcnt + BW'(1);
            cnt    <= k_lat;
            if (bitcnt + BW'(1) == n_lat) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - KW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A read coinciding with completion acknowledges the old frame, so no overrun.
      if (done) begin
        o_data  <= shreg;
        o_ferr  <= ~shreg[DW-1];
        o_rxrdy <= 1'b1;
        o_ovf   <= o_rxrdy & ~i_read;
      end else if (i_read) begin
        o_rxrdy <= 1'b0;
        o_ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rx_bit_engine.md
RX_BIT_ENGINE -- requirements
Module: rx_bit_engine

Interface
REQ-001 SHALL provide port i_clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-002 SHALL provide port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL provide port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-004 SHALL provide port i_k, input, 19 bits: clock cycles per bit time, legal range 2 to 2^19-1.
REQ-005 SHALL provide port i_eight, input, 1 bit: 1 selects 8 data bits, 0 selects 7.
REQ-006 SHALL provide port i_pen, input, 1 bit: 1 means a parity bit follows the data.
REQ-007 SHALL provide port i_read, input, 1 bit: one-cycle pulse from the consumer acknowledging o_data.
REQ-008 SHALL provide port o_data, output, 10 bits: raw shifted frame, left-justified, feeding the downstream remap stage.
REQ-009 SHALL provide port o_rxrdy, output, 1 bit: frame available.
REQ-010 SHALL provide port o_ferr, output, 1 bit: framing error (stop bit sampled 0).
REQ-011 SHALL provide port o_ovf, output, 1 bit: overrun.

Function
REQ-012 SHALL synchronise i_rx through 2 flops, both reset to 1; all decisions use the synchronised value.
REQ-013 SHALL implement three states: IDLE, START, SHIFT.
REQ-014 SHALL stay in IDLE while the synchronised rx is 1, and on 0 SHALL enter START and load the bit-time counter with i_k>>1.
REQ-015 SHALL, in START at counter expiry (mid start bit), return to IDLE if rx is 1 (false start), else enter SHIFT and load the counter with i_k.
REQ-016 SHALL, in SHIFT at each counter expiry, shift rx into bit 9 of a 10-bit shift register (right shift), increment the bit count, and reload the counter with i_k.
REQ-017 SHALL shift exactly N = 8 + i_eight + i_pen bits after the start bit (data LSB first, optional parity, stop).
REQ-018 SHALL reset the shift register to 10'h3FF at entry to START so that unfilled low bits read 1.
REQ-019 SHALL, on the Nth shift, copy the register into o_data in the following cycle, set o_rxrdy, set o_ferr to the sampled stop bit inverted, and return to IDLE.
REQ-020 SHALL start looking for the next start bit immediately in IDLE, with no extra stop-bit wait.
REQ-021 SHALL, if a frame completes while o_rxrdy=1, overwrite o_data and o_ferr and set o_ovf.
REQ-022 SHALL clear o_rxrdy and o_ovf on i_read; completion in the same cycle as i_read leaves o_rxrdy=1 and o_ovf=0.
REQ-023 SHALL sample i_k, i_eight and i_pen at START entry and hold them for the rest of the frame.
REQ-024 SHALL count i_k bits with a 19-bit down counter that expires at 1; i_k=2 gives half-bit time 1.

Reset
REQ-025 SHALL, with i_rst_n=0 at a clock edge, enter IDLE and set o_data=10'h3FF, o_rxrdy=0, o_ferr=0, o_ovf=0, counters=0, synchroniser=1.
REQ-026 SHALL abandon any frame in progress when reset occurs mid-frame, producing no o_rxrdy for it.

Verification
REQ-027 SHALL pass: k=8, 8N1, send 0x55 (stop=1) -> o_data=10'h2AB, o_rxrdy=1, o_ferr=0, about 9.5*k+3 cycles after the start edge.
REQ-028 SHALL pass: k=8, 7N1, send 0x0A -> o_data=10'h22B, o_ferr=0.
REQ-029 SHALL pass: k=8, 8N1, stop bit driven 0 -> o_ferr=1, o_rxrdy=1.
REQ-030 SHALL pass: low glitch of 2 cycles on idle line -> returns to IDLE, no o_rxrdy.
REQ-031 SHALL pass: two back-to-back frames without i_read -> o_ovf=1 and o_data=second frame; then i_read pulse -> o_rxrdy=0, o_ovf=0.
REQ-032 SHALL pass: i_rst_n low mid-frame -> outputs at reset values, no completion pulse; next full frame is received correctly.
